// File: rtl/uart.sv
// uart -- full-duplex 8N1 serial transceiver.
//
// Purpose: bridges a byte-wide valid/ready interface to a pair of serial pins.
// The transmit and receive paths are fully independent. Each bit lasts
// CyclesPerBit = ClockFreq / BaudRate clocks (integer-truncated).
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous, active-high reset
//   DataIn[7:0]   in   byte to transmit
//   DataInValid   in   DataIn holds a byte to send
//   DataInReady   out  transmitter idle, will accept a byte
//   DataOut[7:0]  out  most recently received byte
//   DataOutValid  out  DataOut holds an unconsumed byte
//   DataOutReady  in   consumer takes DataOut
//   SIn           in   serial receive line, idle high
//   SOut          out  serial transmit line, idle high
//
// Build option: define UART_RX_SYNC_EN to pass SIn through a 2-flop
// synchronizer (reset to 1) before the receiver. All receive sampling points
// then move 2 cycles later. Leave it undefined when SIn is already synchronous.

module uart #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    input  logic       SIn,
    output logic       SOut
);

    localparam int CyclesPerBit = ClockFreq / BaudRate;
    localparam int HalfBit      = CyclesPerBit / 2;
    localparam int CntW         = $clog2(CyclesPerBit + 1);

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t BitLast  = cnt_t'(CyclesPerBit - 1);
    localparam cnt_t HalfLast = cnt_t'(HalfBit - 1);
    localparam cnt_t CntOne   = cnt_t'(1);

    // ---------------------------------------------------------------- TX path
    logic       txBusy;
    cnt_t       txCnt;
    logic [3:0] txBitIdx;
    // The frame shifts out LSB first. Ones are shifted in behind it, so
    // txShift[0] is the line level directly and idles high.
    logic [9:0] txShift;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            txBusy   <= 1'b0;
            txCnt    <= '0;
            txBitIdx <= '0;
            txShift  <= '1;
        end else if (!txBusy) begin
            if (DataInValid) begin
                txBusy   <= 1'b1;
                txShift  <= {1'b1, DataIn, 1'b0};
                txCnt    <= '0;
                txBitIdx <= '0;
            end
        end else if (txCnt == BitLast) begin
            txCnt   <= '0;
            txShift <= {1'b1, txShift[9:1]};
            if (txBitIdx == 4'd9) begin
                txBusy <= 1'b0;
            end else begin
                txBitIdx <= txBitIdx + 4'd1;
            end
        end else begin
            txCnt <= txCnt + CntOne;
        end
    end

    assign DataInReady = ~txBusy;
    assign SOut        = txShift[0];

    // ---------------------------------------------------------------- RX input
    logic rxIn;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rxSync;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rxSync <= 2'b11;
        end else begin
            rxSync <= {rxSync[0], SIn};
        end
    end

    assign rxIn = rxSync[1];
`else
    assign rxIn = SIn;
`endif

    // ---------------------------------------------------------------- RX FSM
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rxState_t;

    rxState_t   rxState, rxStateNext;
    cnt_t       rxCnt, rxCntNext;
    logic [2:0] rxBitIdx, rxBitIdxNext;
    logic [7:0] rxShift, rxShiftNext;
    logic       rxErr, rxErrNext;    // stop bit was 0; wait for the line to go high
    logic       rxDone;              // a well-formed byte is complete in rxShift

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rxState  <= RxIdle;
            rxCnt    <= '0;
            rxBitIdx <= '0;
            rxShift  <= '0;
            rxErr    <= 1'b0;
        end else begin
            rxState  <= rxStateNext;
            rxCnt    <= rxCntNext;
            rxBitIdx <= rxBitIdxNext;
            rxShift  <= rxShiftNext;
            rxErr    <= rxErrNext;
        end
    end

    always_comb begin
        rxStateNext  = rxState;
        rxCntNext    = rxCnt;
        rxBitIdxNext = rxBitIdx;
        rxShiftNext  = rxShift;
        rxErrNext    = rxErr;
        rxDone       = 1'b0;
        case (rxState)
            RxIdle: begin
                rxCntNext = '0;
                rxErrNext = 1'b0;
                if (!rxIn) rxStateNext = RxStart;
            end
            RxStart: begin
                // Half a bit in: still low means a real start bit, and every
                // later sample lands at mid-bit.
                if (rxCnt == HalfLast) begin
                    rxCntNext    = '0;
                    rxBitIdxNext = '0;
                    rxStateNext  = rxIn ? RxIdle : RxData;
                end else begin
                    rxCntNext = rxCnt + CntOne;
                end
            end
            RxData: begin
                if (rxCnt == BitLast) begin
                    rxCntNext   = '0;
                    rxShiftNext = {rxIn, rxShift[7:1]};
                    if (rxBitIdx == 3'd7) begin
                        rxStateNext = RxStop;
                    end else begin
                        rxBitIdxNext = rxBitIdx + 3'd1;
                    end
                end else begin
                    rxCntNext = rxCnt + CntOne;
                end
            end
            RxStop: begin
                if (rxErr) begin
                    if (rxIn) rxStateNext = RxIdle;
                end else if (rxCnt == BitLast) begin
                    if (rxIn) begin
                        rxDone      = 1'b1;
                        rxStateNext = RxIdle;
                    end else begin
                        rxErrNext = 1'b1;
                    end
                end else begin
                    rxCntNext = rxCnt + CntOne;
                end
            end
            default: rxStateNext = RxIdle;
        endcase
    end

    // ---------------------------------------------------------------- RX output
    // A byte that completes while the previous one is still unconsumed is
    // dropped, unless the consumer takes the old byte in the same cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            DataOut      <= 8'h00;
            DataOutValid <= 1'b0;
        end else if (rxDone && (!DataOutValid || DataOutReady)) begin
            DataOut      <= rxShift;
            DataOutValid <= 1'b1;
        end else if (DataOutReady) begin
            DataOutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart.sv
module tb_uart;

    localparam int Cpb = 434;

    logic       clock;
    logic       reset;
    logic [7:0] dataIn;
    logic       dataInValid;
    logic       dataInReady;
    logic [7:0] dataOut;
    logic       dataOutValid;
    logic       dataOutReady;
    logic       sIn;
    logic       sOut;
    logic       loopEn;
    logic       sInDrv;

    int checks = 0;
    int errors = 0;

    assign sIn = loopEn ? sOut : sInDrv;

    uart #(.ClockFreq(50_000_000), .BaudRate(115_200)) dut (
        .Clock       (clock),
        .Reset       (reset),
        .DataIn      (dataIn),
        .DataInValid (dataInValid),
        .DataInReady (dataInReady),
        .DataOut     (dataOut),
        .DataOutValid(dataOutValid),
        .DataOutReady(dataOutReady),
        .SIn         (sIn),
        .SOut        (sOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [9:0] expBits;   // bit i = line level during serial bit i
        logic [7:0] expRx;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Send one byte and check every serial bit at mid-bit plus the ready window.
    task automatic sendFrame(input logic [7:0] d, input logic [9:0] expBits);
        @(negedge clock);
        check("ready before send", dataInReady, 1'b1);
        dataIn      = d;
        dataInValid = 1'b1;
        @(posedge clock);
        #1;
        dataInValid = 1'b0;
        dataIn      = ~d;
        check("ready drops after accept", dataInReady, 1'b0);
        repeat (Cpb / 2) @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("sout bit %0d", i), sOut, expBits[i]);
            check("ready low in frame", dataInReady, 1'b0);
            if (i < 9) begin
                repeat (Cpb) @(posedge clock);
                #1;
            end
        end
        repeat (Cpb - Cpb / 2 - 1) @(posedge clock);
        #1;
        check("ready low last frame cycle", dataInReady, 1'b0);
        @(posedge clock);
        #1;
        check("ready back after frame", dataInReady, 1'b1);
        check("sout idle after frame", sOut, 1'b1);
    endtask

    task automatic consume();
        @(negedge clock);
        check("valid before consume", dataOutValid, 1'b1);
        dataOutReady = 1'b1;
        @(posedge clock);
        #1;
        dataOutReady = 1'b0;
        check("valid clears after consume", dataOutValid, 1'b0);
    endtask

    // Bench-driven serial frame with a selectable stop-bit level.
    task automatic driveFrame(input logic [7:0] d, input logic stopBit);
        @(negedge clock);
        sInDrv = 1'b0;
        repeat (Cpb) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            sInDrv = d[i];
            repeat (Cpb) @(negedge clock);
        end
        sInDrv = stopBit;
        repeat (Cpb) @(negedge clock);
        sInDrv = 1'b1;
        repeat (Cpb) @(negedge clock);
    endtask

    initial begin
        vecs[0] = '{data: 8'h7a, expBits: 10'b1011110100, expRx: 8'h7a};
        vecs[1] = '{data: 8'h00, expBits: 10'b1000000000, expRx: 8'h00};
        vecs[2] = '{data: 8'hff, expBits: 10'b1111111110, expRx: 8'hff};
        vecs[3] = '{data: 8'h81, expBits: 10'b1100000010, expRx: 8'h81};

        reset        = 1'b1;
        dataIn       = 8'h00;
        dataInValid  = 1'b0;
        dataOutReady = 1'b0;
        loopEn       = 1'b0;
        sInDrv       = 1'b1;

        // Reset held 30 cycles: outputs at idle values during and after.
        repeat (5) @(posedge clock);
        #1;
        check("rst sout", sOut, 1'b1);
        check("rst ready", dataInReady, 1'b1);
        check("rst valid", dataOutValid, 1'b0);
        check("rst dataout", dataOut, 8'h00);
        repeat (25) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("post-rst sout", sOut, 1'b1);
        check("post-rst ready", dataInReady, 1'b1);
        check("post-rst valid", dataOutValid, 1'b0);

        // Loopback frames from the table: TX waveform, then RX result.
        loopEn = 1'b1;
        for (int v = 0; v < 4; v++) begin
            check("valid idle before frame", dataOutValid, 1'b0);
            sendFrame(vecs[v].data, vecs[v].expBits);
            check("rx valid", dataOutValid, 1'b1);
            check("rx data", dataOut, vecs[v].expRx);
            consume();
        end

        // Reset in the middle of a frame aborts it at once.
        @(negedge clock);
        dataIn      = 8'h00;
        dataInValid = 1'b1;
        @(posedge clock);
        #1;
        dataInValid = 1'b0;
        repeat (1000) @(posedge clock);
        #1;
        check("mid-frame sout low", sOut, 1'b0);
        reset = 1'b1;
        #1;
        check("abort sout", sOut, 1'b1);
        check("abort ready", dataInReady, 1'b1);
        check("abort valid", dataOutValid, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (4000) @(posedge clock);
        #1;
        check("no rx after abort", dataOutValid, 1'b0);
        check("no tx after abort", sOut, 1'b1);

        // Overrun: second byte arrives while the first is unread.
        sendFrame(8'h55, 10'b1010101010);
        sendFrame(8'ha3, 10'b1101000110);
        check("overrun valid", dataOutValid, 1'b1);
        check("overrun keeps first", dataOut, 8'h55);
        consume();

        // A 100-cycle low glitch is rejected.
        loopEn = 1'b0;
        @(negedge clock);
        sInDrv = 1'b0;
        repeat (100) @(negedge clock);
        sInDrv = 1'b1;
        repeat (5000) @(posedge clock);
        #1;
        check("glitch no byte", dataOutValid, 1'b0);

        // Framing error is discarded; the next good frame is received.
        driveFrame(8'h3c, 1'b0);
        #1;
        check("framing error no byte", dataOutValid, 1'b0);
        driveFrame(8'h81, 1'b1);
        #1;
        check("after error valid", dataOutValid, 1'b1);
        check("after error data", dataOut, 8'h81);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Full-duplex 8N1 serial transceiver: one byte-wide transmit path and one byte-wide receive path.
- Each path has a valid/ready handshake on the parallel side.
- Bridges the processor's memory-mapped I/O or a host-side bench model to the FPGA serial pins.
- A baud divider is derived from the clock frequency.

Parameters:
- ClockFreq, 50_000_000, input clock frequency in Hz.
- BaudRate, 115_200, serial bit rate in bits/s.
- Derived constant CyclesPerBit = ClockFreq / BaudRate, integer-truncated; 434 at defaults.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DataIn  input  8  byte to transmit.
- DataInValid  input  1  DataIn holds a byte to send.
- DataInReady  output  1  transmitter idle; will accept a byte.
- DataOut  output  8  most recently received byte.
- DataOutValid  output  1  DataOut holds an unconsumed byte.
- DataOutReady  input  1  consumer takes DataOut.
- SIn  input  1  serial receive line, idle high.
- SOut  output  1  serial transmit line, idle high.

Behaviour:
- Clocking and reset:
  - One clock; Reset is asynchronous and active-high.
  - Reset values: SOut=1, DataInReady=1, DataOutValid=0, DataOut=8'h00.
  - All counters and shift registers clear on Reset.
  - Reset mid-frame aborts the frame immediately; SOut returns high.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Each bit lasts exactly CyclesPerBit clocks.
- TX handshake and timing:
  - A byte is accepted on a rising edge where DataInValid & DataInReady.
  - DataInReady drops the next cycle and stays low for the whole 10-bit frame.
  - SOut drives the start bit starting the cycle after acceptance.
  - DataInReady reasserts after the stop bit has been held CyclesPerBit clocks, i.e. 10*CyclesPerBit cycles after acceptance.
  - DataIn is sampled only at acceptance; later changes do not affect the frame.
  - Back-to-back bytes: the next frame may start the cycle DataInReady is high and valid is high, giving no idle gap.
- RX states: IDLE, START, DATA, STOP.
  - IDLE: waits for SIn low.
  - START: counts CyclesPerBit/2 and re-samples SIn. If SIn is high, the glitch is rejected and the state returns to IDLE.
  - DATA: samples 8 bits at mid-bit, each CyclesPerBit apart, and shifts them in LSB first.
  - STOP: samples the stop bit at mid-bit.
    - If the stop bit is 1, DataOut is loaded and DataOutValid set the next cycle.
    - If the stop bit is 0 (framing error), the byte is discarded and the state returns to IDLE after SIn goes high.
- RX handshake:
  - DataOutValid stays high until a cycle with DataOutReady high, then clears the next cycle.
  - Overrun: if a new byte completes while DataOutValid is still high, the new byte is dropped and DataOut is unchanged.
  - Simultaneous consume and complete in the same cycle: the new byte is loaded and DataOutValid stays high.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: SIn passes through a 2-flop synchronizer, reset to 1, before the RX state machine. All RX sampling points shift 2 cycles later.
- Undefined: SIn feeds the RX logic directly, for use when SIn is already synchronous, e.g. in a loopback bench.

Test Plan:
- Reset held 30 cycles -> SOut=1, DataInReady=1, DataOutValid=0 during and after reset.
- Send DataIn=8'h7a with defaults -> SOut bits are 0,0,1,0,1,1,1,1,0,1, each 434 cycles long. DataInReady is low for 4340 cycles.
- Loop SOut to SIn and send 8'h7a -> DataOutValid rises, DataOut=8'h7a. With DataOutReady pulsed one cycle, valid clears the next cycle.
- Send 8'h55 then 8'hA3 back-to-back without reading -> DataOut stays 8'h55, DataOutValid=1, and 8'hA3 is dropped.
- 100-cycle low glitch on SIn -> no byte received; RX returns to IDLE.
- Frame 8'h3C with stop bit forced 0 -> DataOutValid stays 0. The next well-formed 8'h81 is received correctly.
